// File: rtl/mac_stream_pkg.sv
// Shared types for the MAC operand streamer: beat payload layout, FSM states
// and the credit arithmetic used to keep the 2-entry output FIFO from overflowing.
package mac_stream_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic signed [DATA_W-1:0] inp;
        logic signed [DATA_W-1:0] weight;
    } input_data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIAS   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } streamer_state_t;

    localparam logic TUSER_BIAS = 1'b1;

    // Slots the FIFO will hold next cycle if nothing new is issued now.
    function automatic logic [2:0] credit_used(input logic [1:0] count,
                                               input logic       inflight,
                                               input logic       pop);
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry beat FIFO; the head entry register drives the outputs directly.
// A push is accepted while full only when a pop happens in the same cycle.
module stream_fifo2 #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_user,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_user,
    output logic [1:0]   o_count,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0] r_head_data;
    logic [W-1:0] r_tail_data;
    logic         r_head_last;
    logic         r_tail_last;
    logic         r_head_user;
    logic         r_tail_user;
    logic [1:0]   r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head_data <= '0;
            r_tail_data <= '0;
            r_head_last <= 1'b0;
            r_tail_last <= 1'b0;
            r_head_user <= 1'b0;
            r_tail_user <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= i_data;
                        r_head_last <= i_last;
                        r_head_user <= i_user;
                    end else begin
                        r_tail_data <= i_data;
                        r_tail_last <= i_last;
                        r_tail_user <= i_user;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_head_user <= r_tail_user;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    // With one entry the new beat goes straight to the head.
                    if (r_count == 2'd1) begin
                        r_head_data <= i_data;
                        r_head_last <= i_last;
                        r_head_user <= i_user;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_head_user <= r_tail_user;
                        r_tail_data <= i_data;
                        r_tail_last <= i_last;
                        r_tail_user <= i_user;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_head_data;
    assign o_last  = r_head_last;
    assign o_user  = r_head_user;
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/mac_operand_streamer.sv
// Turns one layer-controller command into a bias beat followed by LEN packed
// {input, weight} beats on an AXI-Stream master, reading both operand memories.
//
// Stream handshake: a beat transfers on MI_AXIS_TVALID && MI_AXIS_TREADY;
// TVALID comes from FIFO occupancy only, and the FIFO head register holds
// TDATA/TLAST/TUSER steady while TVALID && !TREADY.
module mac_operand_streamer
    import mac_stream_pkg::*;
#(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_LEN_WIDTH  = 12
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [2*C_DATA_WIDTH-1:0] CMD_BIAS,
    input  logic [C_ADDR_WIDTH-1:0]   CMD_W_BASE,
    input  logic [C_ADDR_WIDTH-1:0]   CMD_I_BASE,
    input  logic [C_LEN_WIDTH-1:0]    CMD_LEN,
    output logic                      W_RD_EN,
    output logic [C_ADDR_WIDTH-1:0]   W_RD_ADDR,
    input  logic [C_DATA_WIDTH-1:0]   W_RD_DATA,
    output logic                      I_RD_EN,
    output logic [C_ADDR_WIDTH-1:0]   I_RD_ADDR,
    input  logic [C_DATA_WIDTH-1:0]   I_RD_DATA,
    output logic                      MI_AXIS_TVALID,
    input  logic                      MI_AXIS_TREADY,
    output logic [2*C_DATA_WIDTH-1:0] MI_AXIS_TDATA,
    output logic                      MI_AXIS_TLAST,
    output logic                      MI_AXIS_TUSER,
    output logic [7:0]                MI_AXIS_TID,
    output logic                      BUSY,
    output logic                      DONE,
    output streamer_state_t           DBG_STATE
);

    localparam int TW = 2 * C_DATA_WIDTH;
    localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

    streamer_state_t             r_state;
    logic                        r_cmd_ready;
    logic [C_ADDR_WIDTH-1:0]     r_w_base;
    logic [C_ADDR_WIDTH-1:0]     r_i_base;
    logic [C_LEN_WIDTH-1:0]      r_len;
    logic [C_LEN_WIDTH-1:0]      r_k;
    logic                        r_inflight;
    logic                        r_inflight_last;

    logic                        w_accept;
    logic                        w_tvalid;
    logic                        w_pop;
    logic                        w_final;
    logic                        w_issue;
    logic                        w_last_rd;
    logic [C_LEN_WIDTH-1:0]      w_k_next;
    logic [C_ADDR_WIDTH-1:0]     w_k_addr;
    logic                        w_push;
    logic [TW-1:0]               w_push_data;
    logic                        w_push_last;
    logic                        w_push_user;
    logic [TW-1:0]               w_fifo_data;
    logic                        w_fifo_last;
    logic                        w_fifo_user;
    logic [1:0]                  w_fifo_count;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;

    assign w_accept  = CMD_VALID && r_cmd_ready;
    assign w_tvalid  = !w_fifo_empty;
    assign w_pop     = w_tvalid && MI_AXIS_TREADY;
    assign w_final   = w_pop && w_fifo_last;
    assign w_k_next  = r_k + LEN_ONE;
    assign w_last_rd = (w_k_next == r_len);
    assign w_k_addr  = C_ADDR_WIDTH'(r_k);

    // Reads start in BIAS so pair 0 lands right behind the bias beat; the
    // credit test counts the read whose data arrives this cycle as occupied.
    assign w_issue = ((r_state == BIAS) || (r_state == STREAM))
                     && (r_k < r_len)
                     && (credit_used(w_fifo_count, r_inflight, w_pop) < 3'd2)
                     && !(w_fifo_full && !w_pop);

    // Bias is pushed at accept; memory data is pushed one cycle after its read.
    assign w_push      = w_accept || r_inflight;
    assign w_push_data = w_accept ? CMD_BIAS : {I_RD_DATA, W_RD_DATA};
    assign w_push_last = w_accept ? (CMD_LEN == '0) : r_inflight_last;
    assign w_push_user = w_accept ? TUSER_BIAS : 1'b0;

    stream_fifo2 #(
        .W(TW)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_last  (w_push_last),
        .i_user  (w_push_user),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_last  (w_fifo_last),
        .o_user  (w_fifo_user),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state         <= IDLE;
            r_cmd_ready     <= 1'b0;
            r_w_base        <= '0;
            r_i_base        <= '0;
            r_len           <= '0;
            r_k             <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_rd;
            if (w_issue) begin
                r_k <= w_k_next;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_w_base    <= CMD_W_BASE;
                        r_i_base    <= CMD_I_BASE;
                        r_len       <= CMD_LEN;
                        r_k         <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= BIAS;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                BIAS: begin
                    // An empty command can finish on its only beat right here.
                    if (w_final) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else if ((r_len == '0) || (w_issue && w_last_rd)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_issue && w_last_rd) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_final) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CMD_READY      = r_cmd_ready;
    assign W_RD_EN        = w_issue;
    assign I_RD_EN        = w_issue;
    assign W_RD_ADDR      = r_w_base + w_k_addr;
    assign I_RD_ADDR      = r_i_base + w_k_addr;
    assign MI_AXIS_TVALID = w_tvalid;
    assign MI_AXIS_TDATA  = w_fifo_data;
    assign MI_AXIS_TLAST  = w_fifo_last;
    assign MI_AXIS_TUSER  = w_fifo_user;
    assign MI_AXIS_TID    = 8'h00;
    assign BUSY           = (r_state != IDLE);
    assign DONE           = w_final;
    assign DBG_STATE      = r_state;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Bench for mac_operand_streamer: directed vector table, corner sequences
// (stalls, empty command, back-to-back with wrap, mid-stream reset), random runs.
module tb_mac_operand_streamer;
    import mac_stream_pkg::*;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            CMD_VALID;
    logic            CMD_READY;
    logic [15:0]     CMD_BIAS;
    logic [11:0]     CMD_W_BASE;
    logic [11:0]     CMD_I_BASE;
    logic [11:0]     CMD_LEN;
    logic            W_RD_EN;
    logic [11:0]     W_RD_ADDR;
    logic [7:0]      W_RD_DATA = 8'h00;
    logic            I_RD_EN;
    logic [11:0]     I_RD_ADDR;
    logic [7:0]      I_RD_DATA = 8'h00;
    logic            MI_AXIS_TVALID;
    logic            MI_AXIS_TREADY;
    logic [15:0]     MI_AXIS_TDATA;
    logic            MI_AXIS_TLAST;
    logic            MI_AXIS_TUSER;
    logic [7:0]      MI_AXIS_TID;
    logic            BUSY;
    logic            DONE;
    streamer_state_t dbg_state;

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    mac_operand_streamer #(
        .C_DATA_WIDTH(8),
        .C_ADDR_WIDTH(12),
        .C_LEN_WIDTH (12)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .CMD_VALID     (CMD_VALID),
        .CMD_READY     (CMD_READY),
        .CMD_BIAS      (CMD_BIAS),
        .CMD_W_BASE    (CMD_W_BASE),
        .CMD_I_BASE    (CMD_I_BASE),
        .CMD_LEN       (CMD_LEN),
        .W_RD_EN       (W_RD_EN),
        .W_RD_ADDR     (W_RD_ADDR),
        .W_RD_DATA     (W_RD_DATA),
        .I_RD_EN       (I_RD_EN),
        .I_RD_ADDR     (I_RD_ADDR),
        .I_RD_DATA     (I_RD_DATA),
        .MI_AXIS_TVALID(MI_AXIS_TVALID),
        .MI_AXIS_TREADY(MI_AXIS_TREADY),
        .MI_AXIS_TDATA (MI_AXIS_TDATA),
        .MI_AXIS_TLAST (MI_AXIS_TLAST),
        .MI_AXIS_TUSER (MI_AXIS_TUSER),
        .MI_AXIS_TID   (MI_AXIS_TID),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .DBG_STATE     (dbg_state)
    );

    // Operand memories with one-cycle read latency.
    logic [7:0] w_mem [4096];
    logic [7:0] i_mem [4096];
    always @(posedge ACLK) begin
        if (W_RD_EN) W_RD_DATA <= w_mem[W_RD_ADDR];
        if (I_RD_EN) I_RD_DATA <= i_mem[I_RD_ADDR];
    end

    // ---------------- scoreboard state ----------------
    typedef struct {logic [15:0] data; logic last; logic user; int cyc;} beat_t;
    typedef struct {int test; logic [15:0] data; logic last; logic user; int cyc;} vec_t;

    logic [17:0] exp_q[$];
    beat_t       got_q[$];
    int n_vec = 0;
    int n_err = 0;
    int acc_abs = 0, done_abs = 0, done_rel = 0, done_cnt = 0;
    int rd_cnt = 0, issued = 0, popped_data = 0, bias_pending = 0;
    int user_cnt = 0, last_cnt = 0, m_len = 0, outst = 0;
    logic [11:0] m_wb = '0, m_ib = '0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;
    int rdy_mode = 0;
    int pat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command expands into bias + LEN memory pairs.
    task automatic push_expected(input logic [15:0] b, input logic [11:0] wb,
                                 input logic [11:0] ib, input int len);
        input_data_t p;
        exp_q.push_back({b, (len == 0), 1'b1});
        for (int k = 0; k < len; k++) begin
            p.inp    = i_mem[(int'(ib) + k) % 4096];
            p.weight = w_mem[(int'(wb) + k) % 4096];
            exp_q.push_back({p, (k == len - 1), 1'b0});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_q.delete();
            prev_stall   = 1'b0;
            bias_pending = 0;
            issued       = 0;
            popped_data  = 0;
        end else begin
            outst = bias_pending + issued - popped_data;
            if (BUSY) chk("credit_le_2", (outst <= 2), 1);
            chk("rd_en_pair", I_RD_EN, W_RD_EN);
            if (W_RD_EN) begin
                chk("w_addr", W_RD_ADDR, (int'(m_wb) + issued) % 4096);
                chk("i_addr", I_RD_ADDR, (int'(m_ib) + issued) % 4096);
                issued++;
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", MI_AXIS_TVALID, 1);
                chk("hold_beat", {MI_AXIS_TDATA, MI_AXIS_TLAST, MI_AXIS_TUSER}, prev_beat);
            end
            if (MI_AXIS_TVALID && MI_AXIS_TREADY) begin
                chk("tid", MI_AXIS_TID, 0);
                chk("beat_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    chk("beat", {MI_AXIS_TDATA, MI_AXIS_TLAST, MI_AXIS_TUSER}, exp_q.pop_front());
                got_q.push_back('{MI_AXIS_TDATA, MI_AXIS_TLAST, MI_AXIS_TUSER, cyc - acc_abs});
                user_cnt += int'(MI_AXIS_TUSER);
                last_cnt += int'(MI_AXIS_TLAST);
                if (MI_AXIS_TUSER) bias_pending = 0;
                else popped_data++;
            end
            chk("done", DONE, (MI_AXIS_TVALID && MI_AXIS_TREADY && MI_AXIS_TLAST));
            if (DONE) begin
                chk("tuser_count", user_cnt, 1);
                chk("tlast_count", last_cnt, 1);
                chk("read_count", rd_cnt, m_len);
                chk("queue_drained", exp_q.size(), 0);
                done_abs = cyc;
                done_rel = cyc - acc_abs;
                done_cnt++;
            end
            if (CMD_VALID && CMD_READY) begin
                acc_abs      = cyc;
                m_wb         = CMD_W_BASE;
                m_ib         = CMD_I_BASE;
                m_len        = int'(CMD_LEN);
                rd_cnt       = 0;
                user_cnt     = 0;
                last_cnt     = 0;
                issued       = 0;
                popped_data  = 0;
                bias_pending = 1;
                got_q.delete();
                push_expected(CMD_BIAS, CMD_W_BASE, CMD_I_BASE, int'(CMD_LEN));
            end
            prev_stall = MI_AXIS_TVALID && !MI_AXIS_TREADY;
            prev_beat  = {MI_AXIS_TDATA, MI_AXIS_TLAST, MI_AXIS_TUSER};
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        MI_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            pat++;
            case (rdy_mode)
                0:       MI_AXIS_TREADY = 1'b1;
                1:       MI_AXIS_TREADY = ((pat % 4) == 0) || ((pat % 4) == 3);
                default: MI_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send_cmd(input logic [15:0] b, input logic [11:0] wb,
                            input logic [11:0] ib, input logic [11:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge ACLK);
        #1;
        CMD_BIAS   = b;
        CMD_W_BASE = wb;
        CMD_I_BASE = ib;
        CMD_LEN    = len;
        CMD_VALID  = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge ACLK);
            if (CMD_READY) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge ACLK);
        #1;
        CMD_VALID  = 1'b0;
        // Junk on the command bus while busy must not leak into the stream.
        CMD_BIAS   = 16'($urandom);
        CMD_W_BASE = 12'($urandom);
        CMD_I_BASE = 12'($urandom);
        CMD_LEN    = 12'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int start;
        bit ok;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            #1;
            if (done_cnt > start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    vec_t vecs[5];

    task automatic check_table(input int tid, input bit use_cyc);
        int j;
        j = 0;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].test == tid) begin
                if (j < got_q.size()) begin
                    chk("tbl_data", got_q[j].data, vecs[i].data);
                    chk("tbl_last", got_q[j].last, vecs[i].last);
                    chk("tbl_user", got_q[j].user, vecs[i].user);
                    if (use_cyc) chk("tbl_cycle", got_q[j].cyc, vecs[i].cyc);
                end
                j++;
            end
        end
        chk("tbl_beat_count", got_q.size(), j);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        vecs[0] = '{1, 16'h0005, 1'b0, 1'b1, 1};
        vecs[1] = '{1, 16'h0402, 1'b0, 1'b0, 3};
        vecs[2] = '{1, 16'h06FF, 1'b0, 1'b0, 4};
        vecs[3] = '{1, 16'hFE03, 1'b1, 1'b0, 5};
        vecs[4] = '{3, 16'hFFF0, 1'b1, 1'b1, 1};

        for (int a = 0; a < 4096; a++) begin
            w_mem[a] = 8'h00;
            i_mem[a] = 8'h00;
        end
        ARESET = 1'b1;
        CMD_VALID = 1'b0;
        CMD_BIAS = '0;
        CMD_W_BASE = '0;
        CMD_I_BASE = '0;
        CMD_LEN = '0;
        #3;
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_tvalid", MI_AXIS_TVALID, 0);
        chk("rst_tdata", MI_AXIS_TDATA, 0);
        chk("rst_tlast_tuser", {MI_AXIS_TLAST, MI_AXIS_TUSER}, 0);
        chk("rst_rd_en", {W_RD_EN, I_RD_EN}, 0);
        chk("rst_addr", {W_RD_ADDR, I_RD_ADDR}, 0);
        chk("rst_busy_done", {BUSY, DONE}, 0);
        chk("rst_state", dbg_state, IDLE);
        @(posedge ACLK);
        #2 ARESET = 1'b0;
        @(posedge ACLK);
        #1 chk("ready_after_reset", CMD_READY, 1);

        // Directed LEN=3 command, full throughput.
        w_mem[12'h010] = 8'd2;  w_mem[12'h011] = 8'hFF; w_mem[12'h012] = 8'd3;
        i_mem[12'h020] = 8'd4;  i_mem[12'h021] = 8'd6;  i_mem[12'h022] = 8'hFE;
        rdy_mode = 0;
        send_cmd(16'h0005, 12'h010, 12'h020, 12'd3);
        wait_done(200);
        check_table(1, 1'b1);
        chk("done_cycle_len3", done_rel, 5);

        // Same command under 1,0,0,1 backpressure.
        pat = 0;
        rdy_mode = 1;
        send_cmd(16'h0005, 12'h010, 12'h020, 12'd3);
        wait_done(200);
        check_table(1, 1'b0);

        // Empty command: bias-only beat, no reads.
        rdy_mode = 0;
        send_cmd(16'hFFF0, 12'h000, 12'h000, 12'd0);
        wait_done(200);
        check_table(3, 1'b1);
        chk("done_cycle_len0", done_rel, 1);

        // Back-to-back commands with weight address wrap at 0xFFF.
        w_mem[12'hFFF] = 8'h11; w_mem[12'h000] = 8'h22;
        i_mem[12'h7FF] = 8'h33; i_mem[12'h800] = 8'h44; i_mem[12'h100] = 8'h55;
        send_cmd(16'h1234, 12'hFFF, 12'h7FF, 12'd2);
        send_cmd(16'h0042, 12'hFFF, 12'h100, 12'd1);
        chk("b2b_accept_cycle", acc_abs, done_abs + 1);
        wait_done(200);

        // Reset in the middle of a LEN=8 stream.
        for (int a = 0; a < 8; a++) begin
            w_mem[12'h200 + a] = 8'(a + 1);
            i_mem[12'h300 + a] = 8'(a + 9);
        end
        send_cmd(16'h0BAD, 12'h200, 12'h300, 12'd8);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            #1;
            if (got_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("two_beats_before_reset", ok, 1);
        @(posedge ACLK);
        #2 ARESET = 1'b1;
        #1;
        chk("midrst_tvalid", MI_AXIS_TVALID, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_rd_en", W_RD_EN, 0);
        @(negedge ACLK);
        @(posedge ACLK);
        #2 ARESET = 1'b0;
        @(posedge ACLK);
        #1 chk("ready_after_midrst", CMD_READY, 1);
        w_mem[12'h400] = 8'h7F;
        i_mem[12'h500] = 8'h80;
        send_cmd(16'h0077, 12'h400, 12'h500, 12'd1);
        wait_done(200);
        chk("post_reset_beats", got_q.size(), 2);

        // Random commands against the memory model.
        for (int a = 0; a < 4096; a++) begin
            w_mem[a] = 8'($urandom);
            i_mem[a] = 8'($urandom);
        end
        rdy_mode = 2;
        for (int n = 0; n < 25; n++) begin
            send_cmd(16'($urandom), 12'($urandom), 12'($urandom),
                     12'($urandom_range(1, 64)));
            wait_done(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
